// File: rtl/vblank_update_arb.sv
// Two-requester update arbiter that commits parameter words only during vertical blanking.
// Define VBLANK_ARB_FIXED_PRIO_EN for fixed priority (A wins); default build is round-robin.
module vblank_update_arb #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  output logic              upd_valid,
  output logic              upd_src,
  output logic [DATA_W-1:0] upd_data,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {ACTIVE, COMMIT, BLANK} state_t;

  state_t            state, state_nxt;
  logic              vblnk_d;
  logic              rise, fall;
  logic              pend_a, pend_b;
  logic [DATA_W-1:0] slot_a, slot_b;
  logic              commit_en, pick_b, com_a, com_b;
  logic              cap_a, cap_b;
`ifndef VBLANK_ARB_FIXED_PRIO_EN
  logic              rr;
`endif

  assign rise = vblnk && !vblnk_d;
  assign fall = !vblnk && vblnk_d;

  always_comb begin
    state_nxt = state;
    commit_en = 1'b0;
    case (state)
      ACTIVE: if (rise) state_nxt = COMMIT;
      COMMIT: begin
        // A falling edge ends the blank without committing; leftovers wait a frame.
        if (fall)                     state_nxt = ACTIVE;
        else if (!pend_a && !pend_b)  state_nxt = BLANK;
        else                          commit_en = 1'b1;
      end
      BLANK:  if (fall) state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

`ifdef VBLANK_ARB_FIXED_PRIO_EN
  assign pick_b = !pend_a;
`else
  assign pick_b = pend_b && (!pend_a || rr);
`endif

  assign com_a = commit_en && !pick_b;
  assign com_b = commit_en &&  pick_b;

  // A slot being committed this cycle refuses capture; the requester simply retries.
  assign cap_a = req_a && !ack_a && !com_a;
  assign cap_b = req_b && !ack_b && !com_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACTIVE;
      vblnk_d   <= 1'b0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      upd_valid <= 1'b0;
      upd_src   <= 1'b0;
      upd_data  <= '0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == COMMIT);
      vblnk_d   <= vblnk;
      ack_a     <= cap_a;
      ack_b     <= cap_b;
      upd_valid <= commit_en;
      if (rise)      frame_cnt <= frame_cnt + 16'd1;
      if (cap_a)     pend_a <= 1'b1;
      else if (com_a) pend_a <= 1'b0;
      if (cap_b)     pend_b <= 1'b1;
      else if (com_b) pend_b <= 1'b0;
      if (commit_en) begin
        upd_src  <= pick_b;
        upd_data <= pick_b ? slot_b : slot_a;
      end
    end
  end

`ifndef VBLANK_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rr <= 1'b0;
    else if (commit_en) rr <= !pick_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (cap_a) slot_a <= data_a;
    if (cap_b) slot_b <= data_b;
  end

endmodule

// File: tb/tb_vblank_update_arb.sv
// Directed testbench for vblank_update_arb: reset, commit timing, arbitration, latest-wins, short blanks.
module tb_vblank_update_arb;

  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vblnk = 1'b0;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic [DATA_W-1:0] data_a = '0, data_b = '0;
  logic              ack_a, ack_b, upd_valid, upd_src, busy;
  logic [DATA_W-1:0] upd_data;
  logic [15:0]       frame_cnt;

  int checks = 0;
  int errors = 0;

  vblank_update_arb #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .upd_valid(upd_valid), .upd_src(upd_src), .upd_data(upd_data),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; vblnk = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic put_a(input logic [DATA_W-1:0] d);
    int n = 0;
    req_a = 1'b1; data_a = d;
    do begin step(); n++; end while (!ack_a && n < 4);
    req_a = 1'b0;
    checks++;
    if (ack_a !== 1'b1) begin
      errors++; $display("FAIL put_a_ack: no ack_a within %0d cycles, ack_a=%b required 1", n, ack_a);
    end
  endtask

  task automatic put_b(input logic [DATA_W-1:0] d);
    int n = 0;
    req_b = 1'b1; data_b = d;
    do begin step(); n++; end while (!ack_b && n < 4);
    req_b = 1'b0;
    checks++;
    if (ack_b !== 1'b1) begin
      errors++; $display("FAIL put_b_ack: no ack_b within %0d cycles, ack_b=%b required 1", n, ack_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b1; data_a = 24'h123456; vblnk = 1'b0;
    repeat (5) step();
    checks++;
    if ({ack_a, ack_b} !== 2'b00) begin
      errors++; $display("FAIL reset_ack: got %b required 00", {ack_a, ack_b});
    end
    checks++;
    if ({upd_valid, upd_src, upd_data} !== '0) begin
      errors++; $display("FAIL reset_upd: got %b/%b/%h required 0/0/000000", upd_valid, upd_src, upd_data);
    end
    checks++;
    if ({busy, frame_cnt} !== 17'd0) begin
      errors++; $display("FAIL reset_busy_frame: got busy=%b frame=%0d required 0/0", busy, frame_cnt);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ack_a !== 1'b1) begin
      errors++; $display("FAIL reset_first_ack: got %b required 1", ack_a);
    end
    step();
    checks++;
    if (ack_a !== 1'b0) begin
      errors++; $display("FAIL held_req_gap: got %b required 0", ack_a);
    end
    step();
    checks++;
    if (ack_a !== 1'b1) begin
      errors++; $display("FAIL held_req_second_ack: got %b required 1", ack_a);
    end
    req_a = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    put_a(24'h0640C8);
    vblnk = 1'b1;
    step();
    checks++;
    if ({busy, upd_valid, frame_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      errors++; $display("FAIL single_enter: busy=%b valid=%b frame=%0d required 1/0/1", busy, upd_valid, frame_cnt);
    end
    step();
    checks++;
    if ({upd_valid, upd_src, upd_data} !== {1'b1, 1'b0, 24'h0640C8}) begin
      errors++; $display("FAIL single_commit: got %b/%b/%h required 1/0/0640c8", upd_valid, upd_src, upd_data);
    end
    step();
    checks++;
    if ({upd_valid, busy, upd_data} !== {1'b0, 1'b0, 24'h0640C8}) begin
      errors++; $display("FAIL single_blank: valid=%b busy=%b data=%h required 0/0/0640c8", upd_valid, busy, upd_data);
    end
    vblnk = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [DATA_W+1:0] e0, e1;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      case (f)
        0: begin put_a(24'h111111); put_b(24'h222222);
                 e0 = {1'b1, 1'b0, 24'h111111}; e1 = {1'b1, 1'b1, 24'h222222}; end
        1: begin put_a(24'h111112); put_b(24'h222223);
                 e0 = {1'b1, 1'b0, 24'h111112}; e1 = {1'b1, 1'b1, 24'h222223}; end
        2: begin put_a(24'h333333);
                 e0 = {1'b1, 1'b0, 24'h333333}; e1 = '0; end
        default: begin put_a(24'h444444); put_b(24'h555555);
`ifdef VBLANK_ARB_FIXED_PRIO_EN
                 e0 = {1'b1, 1'b0, 24'h444444}; e1 = {1'b1, 1'b1, 24'h555555};
`else
                 e0 = {1'b1, 1'b1, 24'h555555}; e1 = {1'b1, 1'b0, 24'h444444};
`endif
                 end
      endcase
      vblnk = 1'b1;
      step();
      step();
      checks++;
      if ({upd_valid, upd_src, upd_data} !== e0) begin
        errors++; $display("FAIL rr_frame%0d_first: got %h required %h", f, {upd_valid, upd_src, upd_data}, e0);
      end
      if (e1 != '0) begin
        step();
        checks++;
        if ({upd_valid, upd_src, upd_data} !== e1) begin
          errors++; $display("FAIL rr_frame%0d_second: got %h required %h", f, {upd_valid, upd_src, upd_data}, e1);
        end
      end
      step();
      checks++;
      if ({upd_valid, busy} !== 2'b00) begin
        errors++; $display("FAIL rr_frame%0d_done: valid/busy=%b required 00", f, {upd_valid, busy});
      end
      vblnk = 1'b0;
      step();
    end
    checks++;
    if (frame_cnt !== 16'd4) begin
      errors++; $display("FAIL rr_frame_cnt: got %0d required 4", frame_cnt);
    end
  endtask

  task automatic test_latest_wins();
    do_reset();
    put_a(24'h000001);
    put_a(24'h000002);
    vblnk = 1'b1;
    step();
    step();
    checks++;
    if ({upd_valid, upd_src, upd_data} !== {1'b1, 1'b0, 24'h000002}) begin
      errors++; $display("FAIL latest_commit: got %b/%b/%h required 1/0/000002", upd_valid, upd_src, upd_data);
    end
    step();
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL latest_single: valid=%b required 0", upd_valid);
    end
    vblnk = 1'b0;
    step();
  endtask

  task automatic test_short_blank();
    do_reset();
    put_a(24'hAAAAAA);
    put_b(24'hBBBBBB);
    vblnk = 1'b1;
    step();
    step();
    checks++;
    if ({upd_valid, upd_src, upd_data} !== {1'b1, 1'b0, 24'hAAAAAA}) begin
      errors++; $display("FAIL short_first: got %b/%b/%h required 1/0/aaaaaa", upd_valid, upd_src, upd_data);
    end
    vblnk = 1'b0;
    step();
    checks++;
    if ({upd_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL short_cut: valid/busy=%b required 00", {upd_valid, busy});
    end
    step();
    vblnk = 1'b1;
    step();
    step();
    checks++;
    if ({upd_valid, upd_src, upd_data} !== {1'b1, 1'b1, 24'hBBBBBB}) begin
      errors++; $display("FAIL short_next: got %b/%b/%h required 1/1/bbbbbb", upd_valid, upd_src, upd_data);
    end
    step();
    checks++;
    if ({upd_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL short_next_done: valid/busy=%b required 00", {upd_valid, busy});
    end
    vblnk = 1'b0;
    step();
  endtask

  task automatic test_collision();
    do_reset();
    put_a(24'h000010);
    vblnk = 1'b1;
    step();
    req_a = 1'b1; data_a = 24'h000020;
    step();
    checks++;
    if ({upd_valid, upd_data, ack_a} !== {1'b1, 24'h000010, 1'b0}) begin
      errors++; $display("FAIL collide_commit: valid=%b data=%h ack_a=%b required 1/000010/0", upd_valid, upd_data, ack_a);
    end
    step();
    checks++;
    if ({ack_a, busy, upd_valid} !== 3'b100) begin
      errors++; $display("FAIL collide_retry: ack/busy/valid=%b required 100", {ack_a, busy, upd_valid});
    end
    req_a = 1'b0;
    vblnk = 1'b0;
    step();
    vblnk = 1'b1;
    step();
    step();
    checks++;
    if ({upd_valid, upd_src, upd_data} !== {1'b1, 1'b0, 24'h000020}) begin
      errors++; $display("FAIL collide_held: got %b/%b/%h required 1/0/000020", upd_valid, upd_src, upd_data);
    end
    vblnk = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    put_a(24'h0000A1);
    put_b(24'h0000B2);
    vblnk = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({upd_valid, busy, frame_cnt} !== 18'd0) begin
      errors++; $display("FAIL midreset_outputs: valid=%b busy=%b frame=%0d required 0/0/0", upd_valid, busy, frame_cnt);
    end
    vblnk = 1'b0;
    step();
    rst = 1'b1;
    vblnk = 1'b1;
    step();
    checks++;
    if ({busy, frame_cnt} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL midreset_rise: busy=%b frame=%0d required 1/1", busy, frame_cnt);
    end
    step();
    checks++;
    if ({upd_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midreset_discard: valid/busy=%b required 00", {upd_valid, busy});
    end
    vblnk = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_latest_wins();
    test_short_blank();
    test_collision();
    test_reset_mid_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
